// File: rtl/riscv_ex_stage.sv
// Execute stage of the 5-stage RISC-V pipeline: operand forwarding, ALU,
// jump/branch resolution with fetch redirect, and the EX/MEM register bundle.
module riscv_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [4:0]      rd_ppl,
  input  logic [4:0]      rs1_ppl,
  input  logic [4:0]      rs2_ppl,
  input  logic [XLEN-1:0] rs1_data_ppl,
  input  logic [XLEN-1:0] rs2_data_ppl,
  input  logic [XLEN-1:0] imm_ppl,
  input  logic [XLEN-1:0] pc_ppl_out,
  input  logic            alu_src_ppl,
  input  logic [3:0]      alu_ctrl_ppl,
  input  logic            jal_ppl,
  input  logic            jalr_ppl,
  input  logic            branch_ppl,
  input  logic            bne_ppl,
  input  logic            mem_ren_ppl,
  input  logic            mem_wen_ppl,
  input  logic            mem_to_reg_ppl,
  input  logic            reg_wen_ppl,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_wen,
  input  logic [XLEN-1:0] wb_data,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [XLEN-1:0] alu_result_mem,
  output logic [XLEN-1:0] store_data_mem,
  output logic [4:0]      rd_mem,
  output logic            mem_ren_mem,
  output logic            mem_wen_mem,
  output logic            mem_to_reg_mem,
  output logic            reg_wen_mem
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // EX/MEM state
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic [4:0]      rd_q;
  logic            mem_ren_q, mem_wen_q, mem_to_reg_q, reg_wen_q;

  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] target;
  logic            taken;
  logic            mem_fwd_ok;

  // A load in MEM has no data yet, so only ALU results in MEM may forward.
  assign mem_fwd_ok = reg_wen_q && !mem_to_reg_q && (rd_q != 5'd0);

  // Forwarding mux per source: MEM beats WB beats the register-file value.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    fwd_rs1 = rs1_data_ppl;
    fwd_rs2 = rs2_data_ppl;
    if (mem_fwd_ok && rs1_ppl == rd_q)
      fwd_rs1 = alu_result_q;
    else if (wb_reg_wen && wb_rd != 5'd0 && rs1_ppl == wb_rd)
      fwd_rs1 = wb_data;
    if (mem_fwd_ok && rs2_ppl == rd_q)
      fwd_rs2 = alu_result_q;
    else if (wb_reg_wen && wb_rd != 5'd0 && rs2_ppl == wb_rd)
      fwd_rs2 = wb_data;
  end

  assign op_a = fwd_rs1;
  assign op_b = alu_src_ppl ? imm_ppl : fwd_rs2;

  // ALU; unused encodings produce zero.
  always_comb begin
    alu_out = '0;
    case (alu_op_e'(alu_ctrl_ppl))
      ALU_ADD:  alu_out = op_a + op_b;
      ALU_SUB:  alu_out = op_a - op_b;
      ALU_AND:  alu_out = op_a & op_b;
      ALU_OR:   alu_out = op_a | op_b;
      ALU_XOR:  alu_out = op_a ^ op_b;
      ALU_SLL:  alu_out = op_a << op_b[4:0];
      ALU_SRL:  alu_out = op_a >> op_b[4:0];
      ALU_SRA:  alu_out = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
      default:  alu_out = '0;
    endcase
  end

  // Control-transfer resolution; branches compare forwarded rs1/rs2, not operand B.
  always_comb begin
    taken  = jal_ppl | jalr_ppl | (branch_ppl & ((fwd_rs1 == fwd_rs2) ^ bne_ppl));
    target = pc_ppl_out + imm_ppl;
    if (jalr_ppl)
      target = (fwd_rs1 + imm_ppl) & ~{{(XLEN-1){1'b0}}, 1'b1};
  end

  // A frozen pipeline must not redirect; the transfer fires once stall drops.
  assign redirect    = taken & ~stall;
  assign redirect_pc = target;
  assign flush       = redirect;

  // Jumps write the link address instead of the ALU result.
  assign alu_result_d = (jal_ppl | jalr_ppl) ? (pc_ppl_out + 32'd4) : alu_out;
  assign store_data_d = fwd_rs2;

  // EX/MEM register: synchronous clear, hold on stall, otherwise load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      alu_result_q <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_wen_q    <= 1'b0;
    end else if (!stall) begin
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_ppl;
      mem_ren_q    <= mem_ren_ppl;
      mem_wen_q    <= mem_wen_ppl;
      mem_to_reg_q <= mem_to_reg_ppl;
      reg_wen_q    <= reg_wen_ppl;
    end
  end

  assign alu_result_mem = alu_result_q;
  assign store_data_mem = store_data_q;
  assign rd_mem         = rd_q;
  assign mem_ren_mem    = mem_ren_q;
  assign mem_wen_mem    = mem_wen_q;
  assign mem_to_reg_mem = mem_to_reg_q;
  assign reg_wen_mem    = reg_wen_q;

endmodule

// File: tb/tb_riscv_ex_stage.sv
// Self-checking bench for riscv_ex_stage: directed scenarios followed by
// randomized instruction streams compared against a behavioural model.
module tb_riscv_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [4:0]  rd_ppl, rs1_ppl, rs2_ppl;
  logic [31:0] rs1_data_ppl, rs2_data_ppl, imm_ppl, pc_ppl_out;
  logic        alu_src_ppl;
  logic [3:0]  alu_ctrl_ppl;
  logic        jal_ppl, jalr_ppl, branch_ppl, bne_ppl;
  logic        mem_ren_ppl, mem_wen_ppl, mem_to_reg_ppl, reg_wen_ppl;
  logic [4:0]  wb_rd;
  logic        wb_reg_wen;
  logic [31:0] wb_data;
  logic        redirect, flush;
  logic [31:0] redirect_pc, alu_result_mem, store_data_mem;
  logic [4:0]  rd_mem;
  logic        mem_ren_mem, mem_wen_mem, mem_to_reg_mem, reg_wen_mem;

  int checks = 0;
  int errors = 0;

  // Expected EX/MEM contents held by the model.
  logic [31:0] m_res, m_store;
  logic [4:0]  m_rd;
  logic        m_ren, m_wen, m_m2r, m_rwen;

  // Combinational outputs observed in the most recent cycle.
  logic        obs_redir;
  logic [31:0] obs_pc;

  riscv_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .rd_ppl(rd_ppl), .rs1_ppl(rs1_ppl), .rs2_ppl(rs2_ppl),
    .rs1_data_ppl(rs1_data_ppl), .rs2_data_ppl(rs2_data_ppl),
    .imm_ppl(imm_ppl), .pc_ppl_out(pc_ppl_out),
    .alu_src_ppl(alu_src_ppl), .alu_ctrl_ppl(alu_ctrl_ppl),
    .jal_ppl(jal_ppl), .jalr_ppl(jalr_ppl), .branch_ppl(branch_ppl), .bne_ppl(bne_ppl),
    .mem_ren_ppl(mem_ren_ppl), .mem_wen_ppl(mem_wen_ppl),
    .mem_to_reg_ppl(mem_to_reg_ppl), .reg_wen_ppl(reg_wen_ppl),
    .wb_rd(wb_rd), .wb_reg_wen(wb_reg_wen), .wb_data(wb_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .alu_result_mem(alu_result_mem), .store_data_mem(store_data_mem), .rd_mem(rd_mem),
    .mem_ren_mem(mem_ren_mem), .mem_wen_mem(mem_wen_mem),
    .mem_to_reg_mem(mem_to_reg_mem), .reg_wen_mem(reg_wen_mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_in();
    rd_ppl = 0; rs1_ppl = 0; rs2_ppl = 0;
    rs1_data_ppl = 0; rs2_data_ppl = 0; imm_ppl = 0; pc_ppl_out = 0;
    alu_src_ppl = 0; alu_ctrl_ppl = 0;
    jal_ppl = 0; jalr_ppl = 0; branch_ppl = 0; bne_ppl = 0;
    mem_ren_ppl = 0; mem_wen_ppl = 0; mem_to_reg_ppl = 0; reg_wen_ppl = 0;
    wb_rd = 0; wb_reg_wen = 0; wb_data = 0;
  endtask

  // Operand value the instruction should see for source index rs.
  function automatic logic [31:0] ref_src(input logic [4:0] rs, input logic [31:0] rf);
    if (rs != 0 && rs == m_rd && m_rwen && !m_m2r) return m_res;
    if (rs != 0 && rs == wb_rd && wb_reg_wen) return wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      0: return a + b;
      1: return a + (~b + 1);
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      7: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      8: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // One clock of EX: checks combinational outputs, then the registered bundle.
  task automatic cycle(input logic rst_v, input logic stall_v);
    logic [31:0] a, b2, b, tgt, res;
    logic        tk, exp_redir;
    rst = rst_v; stall = stall_v;
    #1;
    a   = ref_src(rs1_ppl, rs1_data_ppl);
    b2  = ref_src(rs2_ppl, rs2_data_ppl);
    b   = alu_src_ppl ? imm_ppl : b2;
    tk  = jal_ppl || jalr_ppl || (branch_ppl && ((a == b2) != bne_ppl));
    tgt = jalr_ppl ? ((a + imm_ppl) & 32'hFFFF_FFFE) : (pc_ppl_out + imm_ppl);
    exp_redir = tk && !stall_v;
    res = (jal_ppl || jalr_ppl) ? pc_ppl_out + 32'd4 : ref_alu(alu_ctrl_ppl, a, b);
    obs_redir = redirect;
    obs_pc    = redirect_pc;
    check("redirect", {31'd0, redirect}, {31'd0, exp_redir});
    check("flush", {31'd0, flush}, {31'd0, exp_redir});
    check("redirect_pc", redirect_pc, tgt);
    @(posedge clk);
    if (rst_v) begin
      m_res = 0; m_store = 0; m_rd = 0; m_ren = 0; m_wen = 0; m_m2r = 0; m_rwen = 0;
    end else if (!stall_v) begin
      m_res = res; m_store = b2; m_rd = rd_ppl;
      m_ren = mem_ren_ppl; m_wen = mem_wen_ppl; m_m2r = mem_to_reg_ppl; m_rwen = reg_wen_ppl;
    end
    #1;
    check("alu_result_mem", alu_result_mem, m_res);
    check("store_data_mem", store_data_mem, m_store);
    check("rd_mem", {27'd0, rd_mem}, {27'd0, m_rd});
    check("ctrl_mem", {28'd0, mem_ren_mem, mem_wen_mem, mem_to_reg_mem, reg_wen_mem},
          {28'd0, m_ren, m_wen, m_m2r, m_rwen});
  endtask

  initial begin
    m_res = 0; m_store = 0; m_rd = 0; m_ren = 0; m_wen = 0; m_m2r = 0; m_rwen = 0;
    obs_redir = 0; obs_pc = 0;
    clear_in();
    rst = 1; stall = 0;
    @(negedge clk);
    cycle(1, 0);
    cycle(1, 0);
    check("reset_result", alu_result_mem, 32'h0);

    // ADD x3 = 7 + 5, then SUB x4, x3, x3 using the MEM forward.
    clear_in();
    rd_ppl = 3; rs1_ppl = 1; rs2_ppl = 2; rs1_data_ppl = 7; rs2_data_ppl = 5;
    alu_ctrl_ppl = 0; reg_wen_ppl = 1;
    cycle(0, 0);
    check("add_7_5", alu_result_mem, 32'd12);
    rd_ppl = 4; rs1_ppl = 3; rs2_ppl = 3; rs1_data_ppl = 99; rs2_data_ppl = 1; alu_ctrl_ppl = 1;
    cycle(0, 0);
    check("sub_mem_fwd", alu_result_mem, 32'd0);

    // WB forward, then the same with wb_rd = x0.
    clear_in();
    wb_rd = 2; wb_reg_wen = 1; wb_data = 32'h55;
    rd_ppl = 5; rs1_ppl = 2; rs1_data_ppl = 32'h10; alu_src_ppl = 1; imm_ppl = 1; reg_wen_ppl = 1;
    cycle(0, 0);
    check("wb_fwd", alu_result_mem, 32'h56);
    wb_rd = 0; rs1_ppl = 0;
    cycle(0, 0);
    check("wb_x0_no_fwd", alu_result_mem, 32'h11);

    // BEQ taken and not taken.
    clear_in();
    pc_ppl_out = 32'h100; imm_ppl = 32'h20; rs1_ppl = 6; rs2_ppl = 7;
    rs1_data_ppl = 9; rs2_data_ppl = 9; branch_ppl = 1;
    cycle(0, 0);
    check("beq_taken", {31'd0, obs_redir}, 32'd1);
    check("beq_target", obs_pc, 32'h120);
    check("beq_no_wen", {31'd0, reg_wen_mem}, 32'd0);
    rs2_data_ppl = 8;
    cycle(0, 0);
    check("beq_not_taken", {31'd0, obs_redir}, 32'd0);

    // BNE equal / unequal.
    bne_ppl = 1; rs2_data_ppl = 9;
    cycle(0, 0);
    check("bne_equal", {31'd0, obs_redir}, 32'd0);
    rs2_data_ppl = 3;
    cycle(0, 0);
    check("bne_unequal", {31'd0, obs_redir}, 32'd1);

    // JALR with odd target bit cleared.
    clear_in();
    pc_ppl_out = 32'h40; rs1_ppl = 8; rs1_data_ppl = 32'h1001; imm_ppl = 2;
    rd_ppl = 1; jalr_ppl = 1; reg_wen_ppl = 1;
    cycle(0, 0);
    check("jalr_target", obs_pc, 32'h1002);
    check("jalr_link", alu_result_mem, 32'h44);
    check("jalr_wen", {31'd0, reg_wen_mem}, 32'd1);

    // JAL held under a 3-cycle stall fires exactly once afterwards.
    clear_in();
    pc_ppl_out = 32'h200; imm_ppl = 32'h80; rd_ppl = 1; jal_ppl = 1; reg_wen_ppl = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1);
      check("jal_stall_quiet", {31'd0, obs_redir}, 32'd0);
      check("jal_stall_hold", alu_result_mem, 32'h44);
    end
    cycle(0, 0);
    check("jal_fires", {31'd0, obs_redir}, 32'd1);
    check("jal_link", alu_result_mem, 32'h204);
    clear_in();
    cycle(0, 0);
    check("jal_once", {31'd0, obs_redir}, 32'd0);

    // SRA sign fill and SLTU unsigned compare.
    clear_in();
    rs1_ppl = 9; rs1_data_ppl = 32'h8000_0000; alu_src_ppl = 1; imm_ppl = 4; alu_ctrl_ppl = 7;
    cycle(0, 0);
    check("sra", alu_result_mem, 32'hF800_0000);
    rs1_data_ppl = 32'hFFFF_FFFF; imm_ppl = 1; alu_ctrl_ppl = 9;
    cycle(0, 0);
    check("sltu", alu_result_mem, 32'd0);

    // Reset in the middle of a stream.
    rd_ppl = 7; reg_wen_ppl = 1; mem_wen_ppl = 1; alu_ctrl_ppl = 0;
    cycle(0, 0);
    cycle(1, 0);
    check("reset_mid", {alu_result_mem[26:0], rd_mem} | {27'd0, reg_wen_mem, mem_wen_mem, 3'd0}, 32'd0);

    // Randomized instruction mix.
    for (int n = 0; n < 400; n++) begin
      int kind;
      clear_in();
      kind = $urandom_range(0, 9);
      rd_ppl = 5'($urandom_range(0, 3));
      rs1_ppl = 5'($urandom_range(0, 3));
      rs2_ppl = 5'($urandom_range(0, 3));
      rs1_data_ppl = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      rs2_data_ppl = ($urandom_range(0, 2) == 0) ? rs1_data_ppl : $urandom;
      imm_ppl = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      pc_ppl_out = $urandom & 32'hFFFF_FFFC;
      alu_src_ppl = 1'($urandom_range(0, 1));
      alu_ctrl_ppl = 4'($urandom_range(0, 15));
      wb_rd = 5'($urandom_range(0, 3));
      wb_reg_wen = 1'($urandom_range(0, 1));
      wb_data = $urandom;
      case (kind)
        0, 1, 2, 3: reg_wen_ppl = 1;
        4: begin branch_ppl = 1; bne_ppl = 1'($urandom_range(0, 1)); end
        5: begin jal_ppl = 1; reg_wen_ppl = 1; end
        6: begin jalr_ppl = 1; reg_wen_ppl = 1; end
        7: begin mem_ren_ppl = 1; mem_to_reg_ppl = 1; reg_wen_ppl = 1; alu_ctrl_ppl = 0; end
        8: begin mem_wen_ppl = 1; alu_ctrl_ppl = 0; end
        default: ;
      endcase
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
